led_pwm_fader: RTL

//  Downstream consumer of the 8-bit LED pattern generator. Accepts a new pattern over a

---
 rtl/led_pwm_fader.sv | 119 +++++++++++
 1 files changed

// File: rtl/led_pwm_fader.sv
// Per-channel PWM LED fader: takes target patterns over valid/ready and ramps each duty toward full/off.
// Optional build macro LED_FADER_GAMMA_EN squares the duty before the PWM compare.
module led_pwm_fader #(
  parameter int unsigned N_LED    = 8,
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned STEP     = 16,
  parameter int unsigned RAMP_DIV = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_LED-1:0] pat_in,
  input  logic             pat_valid,
  output logic             pat_ready,
  output logic [N_LED-1:0] led_out,
  output logic             busy
);

  localparam int unsigned DMAX = (1 << PWM_BITS) - 1;
  localparam int unsigned PW   = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  typedef enum logic {IDLE, RAMP} state_e;

  state_e                state_q, state_d;
  logic [N_LED-1:0]      target_q, target_d;
  logic [PWM_BITS-1:0]   duty_q [N_LED];
  logic [PWM_BITS-1:0]   duty_d [N_LED];
  logic [PW-1:0]         presc_q, presc_d;
  logic [PWM_BITS-1:0]   pwm_cnt_q;
  logic [N_LED-1:0]      led_q, led_d;
  logic                  pat_ready_q, busy_q;
  logic                  accept_c, tick_c, cur_done_c, new_done_c;

  function automatic logic [PWM_BITS-1:0] goal_of(input logic on);
    return on ? PWM_BITS'(DMAX) : '0;
  endfunction

  // One saturating ramp step; the extra MSB catches overflow and borrow.
  function automatic logic [PWM_BITS-1:0] ramp_step(input logic [PWM_BITS-1:0] d, input logic up);
    logic [PWM_BITS:0] s;
    if (up) begin
      s = {1'b0, d} + (PWM_BITS+1)'(STEP);
      return (s > (PWM_BITS+1)'(DMAX)) ? PWM_BITS'(DMAX) : s[PWM_BITS-1:0];
    end else begin
      s = {1'b0, d} - (PWM_BITS+1)'(STEP);
      return s[PWM_BITS] ? '0 : s[PWM_BITS-1:0];
    end
  endfunction

`ifdef LED_FADER_GAMMA_EN
  function automatic logic [PWM_BITS-1:0] cmp_of(input logic [PWM_BITS-1:0] d);
    logic [2*PWM_BITS-1:0] p;
    p = (2*PWM_BITS)'(d) * (2*PWM_BITS)'(d);
    return p[2*PWM_BITS-1:PWM_BITS];
  endfunction
`else
  function automatic logic [PWM_BITS-1:0] cmp_of(input logic [PWM_BITS-1:0] d);
    return d;
  endfunction
`endif

  assign accept_c = pat_valid & pat_ready_q;
  assign tick_c   = (presc_q == PW'(RAMP_DIV - 1));

  // Next-state, ramp and PWM compare logic.
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    presc_d    = tick_c ? '0 : presc_q + PW'(1);
    cur_done_c = 1'b1;
    new_done_c = 1'b1;
    led_d      = '0;
    for (int i = 0; i < N_LED; i++) begin
      duty_d[i] = duty_q[i];
      if (duty_q[i] != goal_of(target_q[i])) cur_done_c = 1'b0;
      if (duty_q[i] != goal_of(pat_in[i]))   new_done_c = 1'b0;
      if (state_q == RAMP && tick_c) duty_d[i] = ramp_step(duty_q[i], target_q[i]);
      led_d[i] = (duty_q[i] == PWM_BITS'(DMAX)) | (pwm_cnt_q < cmp_of(duty_q[i]));
    end
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          target_d = pat_in;
          if (!new_done_c) state_d = RAMP;
        end
      end
      RAMP: begin
        if (cur_done_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      target_q    <= '0;
      presc_q     <= '0;
      pwm_cnt_q   <= '0;
      led_q       <= '0;
      pat_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      for (int i = 0; i < N_LED; i++) duty_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      presc_q     <= presc_d;
      pwm_cnt_q   <= pwm_cnt_q + PWM_BITS'(1);
      led_q       <= led_d;
      pat_ready_q <= (state_d == IDLE);
      busy_q      <= (state_d == RAMP);
      for (int i = 0; i < N_LED; i++) duty_q[i] <= duty_d[i];
    end
  end

  assign pat_ready = pat_ready_q;
  assign busy      = busy_q;
  assign led_out   = led_q;

endmodule
